// File: rtl/shift_pio_chan.sv
// Serial/parallel shift channel for the Pi-side link: sclk/sin are synchronised
// into clk, sout is shifted out and sin shifted in, and completed words land on pdata_out.

module shift_pio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module shift_pio_chan #(
  parameter int WIDTH       = 8,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             aload,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             sclk,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] pdata_out,
  output logic             frame_done,
  output logic [CW-1:0]    bit_count
);
  // line 0 = sclk, line 1 = sin; both see identical latency so a bit set up
  // together with its sclk rise is captured on that rise
  logic [1:0]       raw, syn;
  logic             sclk_s, sin_s, prev_s, rise, fall;
  logic             cap;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic             last_bit;

  assign raw = {sin, sclk};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_sync
      shift_pio_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw[g]),
        .q   (syn[g])
      );
    end
  endgenerate

  assign sclk_s = syn[0];
  assign sin_s  = syn[1];
  assign rise   = sclk_s & ~prev_s;
  assign fall   = ~sclk_s & prev_s;

  always_comb begin
    sr_nxt = LSB_FIRST ? {cap, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], cap};
  end

  assign last_bit = (bit_count == CW'(WIDTH-1));
  assign sout     = LSB_FIRST ? sr[0] : sr[WIDTH-1];

  always_ff @(posedge clk or posedge rst)
    if (rst) prev_s <= 1'b0;
    else     prev_s <= sclk_s;

  // load beats any edge seen in the same cycle; cs low aborts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      cap        <= 1'b0;
      bit_count  <= '0;
      pdata_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!cs) begin
        bit_count <= '0;
      end else if (aload) begin
        sr        <= pdata_in;
        bit_count <= '0;
      end else if (rise) begin
        cap <= sin_s;
      end else if (fall) begin
        sr <= sr_nxt;
        if (last_bit) begin
          bit_count  <= '0;
          pdata_out  <= sr_nxt;
          frame_done <= 1'b1;
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_pio_chan.sv
// Directed bench: three channel instances (8-bit MSB, 8-bit LSB, 16-bit MSB)
// sharing sclk/sin/aload/rst, each enabled by its own cs.

module tb_shift_pio_chan;
  logic clk = 1'b0;
  logic rst, aload, sclk, sin;
  logic cs8, csl, cs16;
  logic [7:0]  pin8, pinl, pout8, poutl;
  logic [15:0] pin16, pout16;
  logic        so8, sol, so16, fd8, fdl, fd16;
  logic [3:0]  bc8, bcl;
  logic [4:0]  bc16;

  int checks = 0, errors = 0;
  int cyc = 0, fd8_n = 0, fdl_n = 0, fd16_n = 0, fd16_t = 0;
  int base, t1;
  logic [15:0] so;

  always #5 clk = ~clk;

  shift_pio_chan #(.WIDTH(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) d8 (
    .clk(clk), .rst(rst), .cs(cs8), .aload(aload), .pdata_in(pin8), .sclk(sclk),
    .sin(sin), .sout(so8), .pdata_out(pout8), .frame_done(fd8), .bit_count(bc8));

  shift_pio_chan #(.WIDTH(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dl (
    .clk(clk), .rst(rst), .cs(csl), .aload(aload), .pdata_in(pinl), .sclk(sclk),
    .sin(sin), .sout(sol), .pdata_out(poutl), .frame_done(fdl), .bit_count(bcl));

  shift_pio_chan #(.WIDTH(16), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) d16 (
    .clk(clk), .rst(rst), .cs(cs16), .aload(aload), .pdata_in(pin16), .sclk(sclk),
    .sin(sin), .sout(so16), .pdata_out(pout16), .frame_done(fd16), .bit_count(bc16));

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fd8)  fd8_n = fd8_n + 1;
    if (fdl)  fdl_n = fdl_n + 1;
    if (fd16) begin fd16_n = fd16_n + 1; fd16_t = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sout_of(input int sel);
    case (sel)
      0:       return so8;
      1:       return sol;
      default: return so16;
    endcase
  endfunction

  // entered and left on a negedge
  task automatic load(input logic [15:0] w);
    pin8 = w[7:0]; pinl = w[7:0]; pin16 = w;
    aload = 1'b1;
    @(negedge clk);
    aload = 1'b0;
  endtask

  // one sclk pulse per bit, 4 clk high / 4 clk low; sout sampled before each rise
  task automatic xfer(input int sel, input logic [15:0] word, input int n,
                      input bit lsb, output logic [15:0] sov);
    sov = '0;
    for (int k = 0; k < n; k++) begin
      sov  = {sov[14:0], sout_of(sel)};
      sin  = lsb ? word[k] : word[n-1-k];
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; aload = 1'b0; sclk = 1'b0; sin = 1'b0;
    cs8 = 1'b0; csl = 1'b0; cs16 = 1'b0;
    pin8 = '0; pinl = '0; pin16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sout", so8, 1'b0);
    chk("rst_bc", bc8, 4'd0);
    chk("rst_pdata", pout8, 8'h00);
    chk("rst_fd", fd8, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // MSB-first full duplex
    cs8 = 1'b1;
    load(16'h00C3);
    base = fd8_n;
    xfer(0, 16'h00B2, 8, 1'b0, so);
    chk("msb_sout_seq", so, 16'h00C3);
    chk("msb_pdata", pout8, 8'hB2);
    chk("msb_fd_pulses", fd8_n - base, 1);
    chk("msb_bc", bc8, 4'd0);

    // reset mid-frame
    load(16'h00A5);
    base = fd8_n;
    xfer(0, 16'h0005, 3, 1'b0, so);
    chk("mid_bc3", bc8, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_sout", so8, 1'b0);
    chk("mid_rst_bc", bc8, 4'd0);
    chk("mid_rst_pdata", pout8, 8'h00);
    chk("mid_rst_fd", fd8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 16'h006D, 8, 1'b0, so);
    chk("post_rst_pdata", pout8, 8'h6D);
    chk("post_rst_fd_pulses", fd8_n - base, 1);

    // load collides with the 8th falling edge
    base = fd8_n;
    xfer(0, 16'h007F, 7, 1'b0, so);
    sin = 1'b1; sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0; pin8 = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    aload = 1'b1;
    @(negedge clk);
    aload = 1'b0;
    repeat (2) @(negedge clk);
    chk("coll_bc", bc8, 4'd0);
    chk("coll_fd_pulses", fd8_n - base, 0);
    chk("coll_pdata_hold", pout8, 8'h6D);
    xfer(0, 16'h00E7, 8, 1'b0, so);
    chk("coll_sout_seq", so, 16'h005A);
    chk("coll_next_pdata", pout8, 8'hE7);
    chk("coll_next_fd", fd8_n - base, 1);

    // cs abort after 5 bits
    base = fd8_n;
    xfer(0, 16'h0015, 5, 1'b0, so);
    cs8 = 1'b0;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_bc", bc8, 4'd0);
    chk("abort_pdata_hold", pout8, 8'hE7);
    chk("abort_fd_none", fd8_n - base, 0);
    cs8 = 1'b1;
    xfer(0, 16'h003C, 8, 1'b0, so);
    chk("abort_pdata", pout8, 8'h3C);
    chk("abort_fd_once", fd8_n - base, 1);
    chk("abort_bc_end", bc8, 4'd0);

    // LSB-first
    cs8 = 1'b0; csl = 1'b1;
    load(16'h0001);
    base = fdl_n;
    xfer(1, 16'h0080, 8, 1'b1, so);
    chk("lsb_sout_seq", so, 16'h0080);
    chk("lsb_pdata", poutl, 8'h80);
    chk("lsb_fd_pulses", fdl_n - base, 1);

    // 16-bit back-to-back frames
    csl = 1'b0; cs16 = 1'b1;
    base = fd16_n;
    xfer(2, 16'h1234, 16, 1'b0, so);
    chk("w16_pdata1", pout16, 16'h1234);
    chk("w16_fd1", fd16_n - base, 1);
    t1 = fd16_t;
    xfer(2, 16'hFFFF, 16, 1'b0, so);
    chk("w16_pdata2", pout16, 16'hFFFF);
    chk("w16_fd2", fd16_n - base, 2);
    chk("w16_fd_spacing", fd16_t - t1, 128);
    chk("w16_bc", bc16, 5'd0);
    chk("idle_lsb_bc", bcl, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_pio_chan.md
Name: shift_pio_chan

Overview:
- Parametrised serial/parallel shift channel for the Pi-side serial link. It is the successor to the load-only, shift-out-only register.
- Samples an asynchronous serial clock (sclk) into the clk domain and shifts data both ways: sout to the Pi, sin from the Pi.
- Counts bits and presents a completed received word on pdata_out with a one-cycle frame_done strobe.
- Bit order is selectable: MSB-first or LSB-first.

Parameters:
- WIDTH, 8, word length in bits (2..32).
- LSB_FIRST, 0, 0 = shift out MSB first, insert at bit 0; 1 = shift out LSB first, insert at bit WIDTH-1.
- SYNC_STAGES, 2, synchroniser flops on sclk and sin (2..3).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  channel select; shift/load operations ignored unless high.
- aload  in  1  parallel load request (qualified by cs).
- pdata_in  in  WIDTH  word to transmit.
- sclk  in  1  serial clock from Pi, asynchronous to clk.
- sin  in  1  serial data from Pi, asynchronous to clk.
- sout  out  1  serial data to Pi.
- pdata_out  out  WIDTH  last completed received word.
- frame_done  out  1  one-clk pulse when a word completes.
- bit_count  out  $clog2(WIDTH+1)  bits shifted in the current frame.

Behaviour:
- Reset (async, rst=1):
  - Clears the shift register, pdata_out, bit_count, frame_done, captured-bit register, all synchroniser flops and the previous-sclk flop to 0.
  - Effect is immediate and holds while rst is high.
  - sout reads 0 during reset.
- Synchronisation:
  - sclk and sin each pass through SYNC_STAGES flops giving sclk_s and sin_s.
  - prev_s holds sclk_s delayed one clk.
  - rise = sclk_s & ~prev_s; fall = ~sclk_s & prev_s. rise and fall are mutually exclusive.
  - The synchroniser and edge detector run regardless of cs.
- Rising edge (rise & cs & ~aload): captured bit <= sin_s. The shift register is unchanged.
- Falling edge (fall & cs & ~aload):
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], captured}.
  - LSB_FIRST=1: sr <= {captured, sr[WIDTH-1:1]}.
  - bit_count increments.
  - If bit_count was WIDTH-1:
    - bit_count wraps to 0.
    - pdata_out <= the new sr value, in the same clk cycle as the shift.
    - frame_done = 1 for exactly that one clk.
- sout = sr[WIDTH-1] (LSB_FIRST=0) or sr[0] (LSB_FIRST=1), combinational from sr.
  - sout changes only after a falling edge or a load, so it is stable across the Pi's rising-edge sample.
- Parallel load (cs & aload on a clk edge):
  - sr <= pdata_in; bit_count <= 0.
  - Load has priority: a rise or fall detected in the same cycle is discarded. The captured bit is not updated and no shift occurs.
  - pdata_out is unchanged.
- cs low:
  - sr and pdata_out hold.
  - bit_count is forced to 0 and the captured bit holds.
  - Edges are discarded.
  - A frame aborted by cs deassertion produces no frame_done.
- Latency:
  - An sclk transition at the pin is acted on SYNC_STAGES+1 clk edges later, counting the first edge that samples it.
  - sclk high and low phases must each last at least SYNC_STAGES+1 clk periods. Faster sclk is out of spec and behaviour is undefined.
- frame_done is 0 in every cycle except the word-completion cycle. Back-to-back frames give one pulse per WIDTH falling edges.
- Reset asserted mid-frame: bit_count returns to 0, the partial word is lost and no frame_done is produced. The next frame starts clean after rst falls.

Test Plan:
- Reset/defaults: assert rst mid-simulation with sr holding 8'hA5 and bit_count=3 → immediately sout=0, bit_count=0, pdata_out=0, frame_done=0.
- MSB-first full duplex (WIDTH=8):
  - Stimulus: cs=1, aload pdata_in=8'hC3, then 8 sclk pulses (high/low 4 clk each) with sin bits 1,0,1,1,0,0,1,0.
  - Required response: sout bit sequence before each rise is 1,1,0,0,0,0,1,1; pdata_out=8'hB2; a single frame_done pulse after the 8th fall; bit_count=0.
- LSB-first: LSB_FIRST=1, load 8'h01, shift in 8'h80 LSB-first → sout is 1 then seven 0s; pdata_out=8'h80.
- Load/edge collision: assert aload in the same cycle a fall is detected, with pdata_in=8'h5A → sr=8'h5A, bit_count=0, no shift, no frame_done.
- cs abort: shift 5 bits, drop cs for 10 clk, raise cs, shift 8 bits → frame_done pulses exactly once (after the 8 bits); pdata_out equals the 8-bit word; during cs=0, sclk toggles change nothing.
- Back-to-back frames with WIDTH=16, 2 frames 16'h1234 then 16'hFFFF → two frame_done pulses 16 falls apart; pdata_out=16'h1234 then 16'hFFFF.
